// File: rtl/sram_pkg.sv
// FSM encoding and default parameter values shared by the SRAM port controller.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } sram_state_t;

  localparam int          DEF_ADDR_W      = 16;
  localparam int          DEF_RAM_ADDR_W  = 18;
  localparam int          DEF_DATA_W      = 16;
  localparam int          DEF_WAIT_CYCLES = 1;
  localparam logic [15:0] DEF_RESET_DATA  = 16'h0800;

endpackage

// File: rtl/sram_port_ctrl.sv
// Single-port asynchronous SRAM controller: one request at a time, sequenced
// through setup, strobe and recovery phases with registered active-low strobes.
module sram_port_ctrl
  import sram_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                RAM_ADDR_W  = DEF_RAM_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [DATA_W-1:0] RESET_DATA  = DATA_W'(DEF_RESET_DATA)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  RAMEN,
  output logic                  RAMOE,
  output logic                  RAMWE,
  output logic [RAM_ADDR_W-1:0] RAMADDR,
  inout  wire  [DATA_W-1:0]     RAMDATA
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  if (ADDR_W > RAM_ADDR_W) begin : g_addr_w_chk
    $error("sram_port_ctrl: ADDR_W must not exceed RAM_ADDR_W");
  end
  if (WAIT_CYCLES < 1) begin : g_wait_chk
    $error("sram_port_ctrl: WAIT_CYCLES must be at least 1");
  end

  sram_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // Bus is released combinationally from state, so a reset frees it at once.
  assign RAMDATA = (we_q && state != ST_IDLE) ? wdata_q : {DATA_W{1'bz}};

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // a blocking = would make later lines in the block see half-updated state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      RAMEN     <= 1'b1;
      RAMOE     <= 1'b1;
      RAMWE     <= 1'b1;
      RAMADDR   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= RESET_DATA;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_SETUP;
            we_q    <= req_we;
            RAMADDR <= RAM_ADDR_W'(req_addr);
            RAMEN   <= 1'b0;
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
          cnt   <= CNT_W'(WAIT_CYCLES);
          RAMOE <= we_q;
          RAMWE <= !we_q;
        end
        ST_ACCESS: begin
          if (cnt == CNT_W'(1)) begin
            state     <= ST_RECOVER;
            cnt       <= '0;
            RAMOE     <= 1'b1;
            RAMWE     <= 1'b1;
            rsp_valid <= 1'b1;
            if (!we_q) begin
              rsp_rdata <= RAMDATA;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RECOVER: begin
          state     <= ST_IDLE;
          RAMEN     <= 1'b1;
          rsp_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the write-data holding register has no reset; it only reaches the
  // bus while a write is in flight, and reset cancels any write in flight.
  always_ff @(posedge CLK) begin
    if (accept) begin
      wdata_q <= req_wdata;
    end
  end

endmodule
